// File: rtl/button_counter_ctrl.sv
// Two-button up/down value controller: synchronise, debounce on a prescaled tick,
// generate press/auto-repeat steps and keep a bounded value with wrap or saturate.
module button_counter_ctrl #(
    parameter int unsigned TICK_DIV     = 500_000,
    parameter int unsigned DEBOUNCE_N   = 3,
    parameter int unsigned REPEAT_EN    = 1,
    parameter int unsigned HOLD_TICKS   = 25,
    parameter int unsigned REPEAT_TICKS = 5,
    parameter int unsigned BTN_ACTIVE   = 1,
    parameter int unsigned DATA_W       = 4,
    parameter int unsigned MIN_VAL      = 0,
    parameter int unsigned MAX_VAL      = 9,
    parameter int unsigned INIT_VAL     = 2,
    parameter int unsigned STEP         = 1,
    parameter int unsigned WRAP         = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              button_add,
    input  logic              button_sub,
    output logic [DATA_W-1:0] button_data,
    output logic              add_evt,
    output logic              sub_evt,
    output logic              limit_evt
);

    localparam int unsigned TICK_W  = $clog2(TICK_DIV);
    localparam int unsigned DB_W    = $clog2(DEBOUNCE_N + 1);
    localparam int unsigned CNT_MAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned VW      = DATA_W + 1;
    localparam int unsigned NB      = 2;

    localparam logic          ACT    = 1'(BTN_ACTIVE);
    localparam logic [VW-1:0] HI_THR = VW'(MAX_VAL - STEP);
    localparam logic [VW-1:0] LO_THR = VW'(MIN_VAL + STEP);
    localparam logic [VW-1:0] STEP_V = VW'(STEP);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HOLD   = 2'd1,
        S_REPEAT = 2'd2
    } state_t;

    // Index 0 is the add button, index 1 the sub button throughout.
    logic [NB-1:0]     raw_c;
    logic [NB-1:0]     sync1_q;
    logic [NB-1:0]     sync2_q;
    logic [NB-1:0]     p_c;
    logic [TICK_W-1:0] div_q;
    logic              tick_c;
    logic [NB-1:0]     db_q;
    logic [NB-1:0]     db_d;
    logic [DB_W-1:0]   filt_q [NB];
    logic [DB_W-1:0]   filt_d [NB];
    logic [NB-1:0]     press_c;
    logic [NB-1:0]     release_c;
    state_t            state_q [NB];
    state_t            state_d [NB];
    logic [CNT_W-1:0]  hcnt_q [NB];
    logic [CNT_W-1:0]  hcnt_d [NB];
    logic [NB-1:0]     step_c;
    logic [NB-1:0]     req_q;
    logic [VW-1:0]     cur_c;

    assign raw_c  = {button_sub, button_add};
    assign p_c    = sync2_q ^ {NB{~ACT}};
    assign tick_c = (div_q == TICK_W'(TICK_DIV - 1));
    assign cur_c  = {1'b0, button_data};

    // Pin synchronisers, reset to the released level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= {NB{~ACT}};
            sync2_q <= {NB{~ACT}};
        end else begin
            sync1_q <= raw_c;
            sync2_q <= sync1_q;
        end
    end

    // Sample-tick prescaler.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
        end else if (tick_c) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + TICK_W'(1);
        end
    end

    // Consecutive-sample filter; a flip reports press (0->1) or release (1->0).
    always_comb begin
        db_d      = db_q;
        filt_d    = filt_q;
        press_c   = '0;
        release_c = '0;
        for (int b = 0; b < NB; b++) begin
            if (tick_c) begin
                if (p_c[b] != db_q[b]) begin
                    if (filt_q[b] == DB_W'(DEBOUNCE_N - 1)) begin
                        db_d[b]      = ~db_q[b];
                        filt_d[b]    = '0;
                        press_c[b]   = ~db_q[b];
                        release_c[b] = db_q[b];
                    end else begin
                        filt_d[b] = filt_q[b] + DB_W'(1);
                    end
                end else begin
                    filt_d[b] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            db_q <= '0;
            for (int b = 0; b < NB; b++) begin
                filt_q[b] <= '0;
            end
        end else begin
            db_q <= db_d;
            for (int b = 0; b < NB; b++) begin
                filt_q[b] <= filt_d[b];
            end
        end
    end

    // Repeat FSM next state; release wins over a coincident repeat.
    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        step_c  = '0;
        for (int b = 0; b < NB; b++) begin
            if (release_c[b]) begin
                state_d[b] = S_IDLE;
                hcnt_d[b]  = '0;
            end else if (tick_c) begin
                case (state_q[b])
                    S_IDLE: begin
                        if (press_c[b]) begin
                            state_d[b] = S_HOLD;
                            hcnt_d[b]  = '0;
                            step_c[b]  = 1'b1;
                        end
                    end
                    S_HOLD: begin
                        if (REPEAT_EN != 0) begin
                            if (hcnt_q[b] == CNT_W'(HOLD_TICKS - 1)) begin
                                state_d[b] = S_REPEAT;
                                hcnt_d[b]  = '0;
                                step_c[b]  = 1'b1;
                            end else begin
                                hcnt_d[b] = hcnt_q[b] + CNT_W'(1);
                            end
                        end
                    end
                    S_REPEAT: begin
                        if (hcnt_q[b] == CNT_W'(REPEAT_TICKS - 1)) begin
                            hcnt_d[b] = '0;
                            step_c[b] = 1'b1;
                        end else begin
                            hcnt_d[b] = hcnt_q[b] + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_d[b] = S_IDLE;
                        hcnt_d[b]  = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < NB; b++) begin
                state_q[b] <= S_IDLE;
                hcnt_q[b]  <= '0;
            end
            req_q <= '0;
        end else begin
            for (int b = 0; b < NB; b++) begin
                state_q[b] <= state_d[b];
                hcnt_q[b]  <= hcnt_d[b];
            end
            req_q <= step_c;
        end
    end

    // Value update and event pulses, one clk after the registered request.
    always_ff @(posedge clk) begin
        if (rst) begin
            button_data <= DATA_W'(INIT_VAL);
            add_evt     <= 1'b0;
            sub_evt     <= 1'b0;
            limit_evt   <= 1'b0;
        end else begin
            add_evt   <= 1'b0;
            sub_evt   <= 1'b0;
            limit_evt <= 1'b0;
            case (req_q)
                2'b01: begin
                    add_evt <= 1'b1;
                    if (cur_c > HI_THR) begin
                        button_data <= (WRAP != 0) ? DATA_W'(MIN_VAL) : DATA_W'(MAX_VAL);
                        limit_evt   <= 1'b1;
                    end else begin
                        button_data <= DATA_W'(cur_c + STEP_V);
                    end
                end
                2'b10: begin
                    sub_evt <= 1'b1;
                    if (cur_c < LO_THR) begin
                        button_data <= (WRAP != 0) ? DATA_W'(MAX_VAL) : DATA_W'(MIN_VAL);
                        limit_evt   <= 1'b1;
                    end else begin
                        button_data <= DATA_W'(cur_c - STEP_V);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_button_counter_ctrl.sv
// Bench for button_counter_ctrl: three instances (single-step wrap, repeat wrap,
// repeat saturate) driven from a press table; events are scoreboarded in order.
module tb_button_counter_ctrl;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       add_in [3];
    logic       sub_in [3];
    logic [3:0] data_o [3];
    logic       add_e  [3];
    logic       sub_e  [3];
    logic       lim_e  [3];

    int cyc;
    int mark_cyc;
    int n_checks;
    int n_fail;
    int cur [3];

    typedef struct {
        int         inst;
        logic [6:0] val;
        int         gmin;
        int         gmax;
    } exp_t;

    typedef struct {
        int   inst;
        logic a;
        logic s;
        int   ticks;
    } vec_t;

    typedef struct {
        int   vi;
        int   data;
        logic lim;
    } ev_t;

    exp_t sbq [$];
    vec_t vq  [$];
    ev_t  evq [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    button_counter_ctrl #(
        .TICK_DIV(4), .DEBOUNCE_N(3), .REPEAT_EN(0), .HOLD_TICKS(8), .REPEAT_TICKS(4), .WRAP(1)
    ) u_one (
        .clk(clk), .rst(rst), .button_add(add_in[0]), .button_sub(sub_in[0]),
        .button_data(data_o[0]), .add_evt(add_e[0]), .sub_evt(sub_e[0]), .limit_evt(lim_e[0])
    );

    button_counter_ctrl #(
        .TICK_DIV(4), .DEBOUNCE_N(3), .REPEAT_EN(1), .HOLD_TICKS(8), .REPEAT_TICKS(4), .WRAP(1)
    ) u_rep (
        .clk(clk), .rst(rst), .button_add(add_in[1]), .button_sub(sub_in[1]),
        .button_data(data_o[1]), .add_evt(add_e[1]), .sub_evt(sub_e[1]), .limit_evt(lim_e[1])
    );

    button_counter_ctrl #(
        .TICK_DIV(4), .DEBOUNCE_N(3), .REPEAT_EN(1), .HOLD_TICKS(8), .REPEAT_TICKS(4), .WRAP(0)
    ) u_sat (
        .clk(clk), .rst(rst), .button_add(add_in[2]), .button_sub(sub_in[2]),
        .button_data(data_o[2]), .add_evt(add_e[2]), .sub_evt(sub_e[2]), .limit_evt(lim_e[2])
    );

    function automatic void check_eq(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic void check_rng(string name, int act, int lo, int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endfunction

    function automatic void push_exp(int inst, logic [6:0] val, int lo, int hi);
        exp_t e;
        e.inst = inst;
        e.val  = val;
        e.gmin = lo;
        e.gmax = hi;
        sbq.push_back(e);
    endfunction

    function automatic void add_v(int inst, logic a, logic s, int ticks);
        vec_t v;
        v.inst  = inst;
        v.a     = a;
        v.s     = s;
        v.ticks = ticks;
        vq.push_back(v);
    endfunction

    function automatic void add_e_(int data, logic lim);
        ev_t e;
        e.vi   = vq.size() - 1;
        e.data = data;
        e.lim  = lim;
        evq.push_back(e);
    endfunction

    // Advance to the next falling edge and score any event pulse seen there.
    task automatic step_clk();
        logic [6:0] act;
        exp_t       e;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            if (add_e[i] || sub_e[i] || lim_e[i]) begin
                act = {add_e[i], sub_e[i], lim_e[i], data_o[i]};
                if (sbq.size() == 0 || sbq[0].inst != i) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_evt inst=%0d got=%h expected=none", i, act);
                end else begin
                    e = sbq.pop_front();
                    check_eq($sformatf("evt_inst%0d{add,sub,lim,data}", i), int'(act), int'(e.val));
                    if (e.gmax != 0) begin
                        check_rng($sformatf("evt_gap_inst%0d", i), cyc - mark_cyc, e.gmin, e.gmax);
                    end
                    mark_cyc = cyc;
                end
            end
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (sbq.size() != 0 && n < budget) begin
            step_clk();
            n++;
        end
        check_eq("events_pending", sbq.size(), 0);
        if (sbq.size() != 0) sbq.delete();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int k;
        int lo;
        int hi;
        int last;

        // Press table: instance, add, sub, held ticks, then the expected steps.
        add_v(0, 1'b1, 1'b0, 20); add_e_(3, 1'b0);
        for (int d = 4; d <= 8; d++) begin
            add_v(0, 1'b1, 1'b0, 5); add_e_(d, 1'b0);
        end
        add_v(0, 1'b1, 1'b0, 5); add_e_(9, 1'b0);
        add_v(0, 1'b1, 1'b0, 5); add_e_(0, 1'b1);
        add_v(0, 1'b1, 1'b0, 5); add_e_(1, 1'b0);
        add_v(1, 1'b0, 1'b1, 30);
        add_e_(1, 1'b0); add_e_(0, 1'b0); add_e_(9, 1'b1); add_e_(8, 1'b0);
        add_e_(7, 1'b0); add_e_(6, 1'b0); add_e_(5, 1'b0);
        add_v(1, 1'b1, 1'b1, 20);
        add_v(2, 1'b1, 1'b0, 30);
        for (int d = 3; d <= 9; d++) add_e_(d, 1'b0);
        add_v(2, 1'b1, 1'b0, 5); add_e_(9, 1'b1);
        add_v(2, 1'b0, 1'b1, 42);
        for (int d = 8; d >= 0; d--) add_e_(d, 1'b0);
        add_e_(0, 1'b1);
        add_v(2, 1'b0, 1'b1, 5); add_e_(0, 1'b1);

        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            add_in[i] = 1'b0;
            sub_in[i] = 1'b0;
            cur[i]    = 2;
        end
        repeat (3) step_clk();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("reset_data_inst%0d", i), int'(data_o[i]), 2);
            check_eq($sformatf("reset_evt_inst%0d", i), int'({add_e[i], sub_e[i], lim_e[i]}), 0);
        end
        repeat (2) step_clk();

        for (int i = 0; i < vq.size(); i++) begin
            k = 0;
            for (int j = 0; j < evq.size(); j++) begin
                if (evq[j].vi == i) begin
                    lo = (k == 0) ? 12 : ((k == 1) ? 32 : 16);
                    hi = (k == 0) ? 20 : lo;
                    push_exp(vq[i].inst, {vq[i].a, vq[i].s, evq[j].lim, 4'(evq[j].data)}, lo, hi);
                    cur[vq[i].inst] = evq[j].data;
                    k++;
                end
            end
            mark_cyc = cyc;
            add_in[vq[i].inst] = vq[i].a;
            sub_in[vq[i].inst] = vq[i].s;
            repeat (vq[i].ticks * TD) step_clk();
            add_in[vq[i].inst] = 1'b0;
            sub_in[vq[i].inst] = 1'b0;
            drain(200);
            repeat (6 * TD) step_clk();
            check_eq($sformatf("vec%0d_data", i), int'(data_o[vq[i].inst]), cur[vq[i].inst]);
        end

        // Bounce: add toggles every tick, never stable for three samples.
        for (int t = 0; t < 10; t++) begin
            add_in[0] = (t % 2 == 0);
            repeat (TD) step_clk();
        end
        add_in[0] = 1'b0;
        repeat (8 * TD) step_clk();
        check_eq("bounce_data", int'(data_o[0]), cur[0]);

        // Reset while u_rep sits in the repeat state with add still held.
        mark_cyc  = cyc;
        add_in[1] = 1'b1;
        push_exp(1, {3'b100, 4'd6}, 12, 20);
        push_exp(1, {3'b100, 4'd7}, 32, 32);
        drain(300);
        repeat (8) step_clk();
        rst      = 1'b1;
        mark_cyc = cyc;
        push_exp(1, {3'b100, 4'd3}, 14, 14);
        step_clk();
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("midhold_rst_data_inst%0d", i), int'(data_o[i]), 2);
            check_eq($sformatf("midhold_rst_evt_inst%0d", i), int'({add_e[i], sub_e[i], lim_e[i]}), 0);
        end
        rst = 1'b0;
        drain(100);
        repeat (4) step_clk();
        add_in[1] = 1'b0;
        repeat (8 * TD) step_clk();
        last = int'(data_o[1]);
        check_eq("post_rst_press_data", last, 3);
        check_eq("post_rst_other_data", int'(data_o[2]), 2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
